bcd_to_bin_seq: RTL and testbench



---
 rtl/bcd_to_bin_seq.sv | 79 +++++++
 tb/tb_bcd_to_bin_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: folds six packed BCD digits MSD-first into a 20-bit binary value, one digit per clock
// Ports: clk/rst (async active-high); bcd_in/in_valid/in_ready request handshake;
// value/err/out_valid/out_ready result handshake; busy high while converting or holding a result.
module bcd_to_bin_seq #(
  parameter int NUM_DIGITS = 6,
  parameter int VALUE_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS*4-1:0] bcd_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [VALUE_W-1:0]      value,
  output logic                    err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t                  r_state;
  logic [VALUE_W-1:0]      r_acc;
  logic [NUM_DIGITS*4-1:0] r_shreg;
  logic [2:0]              r_cnt;
  logic                    r_err;
  logic [3:0]              w_d;
  logic [VALUE_W-1:0]      w_acc_next;
  logic                    w_err_next;
  assign w_d = r_shreg[NUM_DIGITS*4-1 -: 4];
  // acc*10 as acc*8 + acc*2; illegal nibbles may wrap, but such results are masked anyway
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + VALUE_W'(w_d);
  assign w_err_next = r_err | (w_d > 4'd9);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      value     <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_shreg  <= bcd_in;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_err    <= 1'b0;
          r_state  <= CONV;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        CONV: begin
          r_acc   <= w_acc_next;
          r_err   <= w_err_next;
          r_shreg <= r_shreg << 4;
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'(NUM_DIGITS - 1)) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            value     <= w_err_next ? '0 : w_acc_next;
            err       <= w_err_next;
          end
        end
        DONE: if (out_ready) begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
          value     <= '0;
          err       <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: scoreboard bench for bcd_to_bin_seq with directed vectors
module tb_bcd_to_bin_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] bcd_in;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] value;
  logic        err;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  typedef struct {
    logic [19:0] val;
    logic        e;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   prev_ov = 0;
  bcd_to_bin_seq dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .in_valid(in_valid), .in_ready(in_ready),
    .value(value), .err(err), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst) prev_ov = 0;
    else begin
      check(!(in_ready && out_valid), "ready_valid_exclusive", int'(in_ready), 0);
      if (out_valid) begin
        if (sb.size() == 0) check(0, "unexpected_output", int'(value), -1);
        else begin
          check(value == sb[0].val, "value", int'(value), int'(sb[0].val));
          check(err == sb[0].e, "err", int'(err), int'(sb[0].e));
          check(busy == 1'b1, "busy_done", int'(busy), 1);
          if (!prev_ov) check(cyc - sb[0].cyc == 6, "latency", cyc - sb[0].cyc, 6);
          if (out_ready) void'(sb.pop_front());
        end
      end else check(value == 0 && err == 0, "idle_outputs_zero", int'(value), 0);
      prev_ov = out_valid;
    end
  end
  task automatic send(input logic [23:0] b, input logic [19:0] v, input bit e, input bit push);
    int n = 0;
    bcd_in = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 40);
    if (!in_ready) check(0, "accept_timeout", n, 40);
    else begin
      last_acc = cyc + 1;
      if (push) sb.push_back('{val: v, e: e, cyc: cyc + 1});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    check(in_ready == 1'b0, "in_ready_drop", int'(in_ready), 0);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      n++;
    end
    check(sb.size() == 0 && !out_valid, "drain_timeout", sb.size(), 0);
    #1;
  endtask
  initial begin
    int a1;
    int n;
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b0;
    bcd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check(in_ready == 1 && out_valid == 0 && value == 0 && err == 0 && busy == 0, "reset_state",
          int'({in_ready, out_valid, err, busy}), 8);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(24'h000146, 20'd146, 0, 1);
    wait_idle();
    send(24'h000000, 20'd0, 0, 1);
    wait_idle();
    send(24'h999999, 20'd999999, 0, 1);
    wait_idle();
    send(24'h100000, 20'd100000, 0, 1);
    wait_idle();
    send(24'h000009, 20'd9, 0, 1);
    wait_idle();
    send(24'h12A456, 20'd0, 1, 1);
    send(24'h000007, 20'd7, 0, 1);
    wait_idle();
    out_ready = 1'b0;
    send(24'h654321, 20'd654321, 0, 1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
    end
    check(out_valid == 1'b1, "bp_out_valid_timeout", n, 40);
    repeat (3) @(posedge clk);
    #1 bcd_in = 24'h000005;
    in_valid = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1 check(in_ready == 1'b0 && out_valid == 1'b1, "bp_stall_ignore_input", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 check(out_valid == 1'b0 && in_ready == 1'b1, "bp_release_idle", int'(out_valid), 0);
    wait_idle();
    send(24'h000001, 20'd1, 0, 1);
    a1 = last_acc;
    send(24'h000002, 20'd2, 0, 1);
    check(last_acc - a1 == 8, "b2b_accept_spacing", last_acc - a1, 8);
    wait_idle();
    send(24'h123456, 20'd0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 check(out_valid == 0 && in_ready == 1 && value == 0 && busy == 0, "reset_mid_conv",
             int'({out_valid, in_ready, busy}), 2);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 send(24'h000146, 20'd146, 0, 1);
    wait_idle();
    check(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
